// File: rtl/mem_config_queue.sv
// Multi-stream descriptor queue programmed over the config bus.
// Each stream pairs a staged VADDR with a SIZE write into a FWFT FIFO.
module mem_config_queue #(
    parameter int         NUM_STREAMS = 4,
    parameter int         DEPTH       = 64,
    parameter int         VADDR_BITS  = 64,
    parameter int         SIZE_BITS   = 32,
    parameter int         ADDR_BITS   = 8,
    parameter int         DATA_BITS   = 64,
    parameter logic [7:0] BLOCK_ID    = 8'h03
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_valid,
    input  logic [ADDR_BITS-1:0]              wr_addr,
    input  logic [DATA_BITS-1:0]              wr_data,
    input  logic                              rd_valid,
    input  logic [ADDR_BITS-1:0]              rd_addr,
    output logic                              rd_resp_valid,
    output logic [DATA_BITS-1:0]              rd_data,
    output logic [NUM_STREAMS-1:0]            buf_valid,
    input  logic [NUM_STREAMS-1:0]            buf_ready,
    output logic [NUM_STREAMS*VADDR_BITS-1:0] buf_vaddr,
    output logic [NUM_STREAMS*SIZE_BITS-1:0]  buf_size,
    output logic [NUM_STREAMS-1:0]            flush
);
    localparam int CNT_BITS = $clog2(DEPTH + 1);
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam logic [ADDR_BITS-1:0] FLUSH_ALL_ADDR = ADDR_BITS'(4 * NUM_STREAMS);
    localparam logic [ADDR_BITS-1:0] ID_ADDR = ADDR_BITS'(4 * NUM_STREAMS + 1);

    logic [VADDR_BITS-1:0] mem_vaddr [NUM_STREAMS][DEPTH];
    logic [SIZE_BITS-1:0]  mem_size  [NUM_STREAMS][DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr    [NUM_STREAMS];
    logic [PTR_BITS-1:0]   rd_ptr    [NUM_STREAMS];
    logic [CNT_BITS-1:0]   count     [NUM_STREAMS];
    logic [VADDR_BITS-1:0] staged_vaddr [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] staged;
    logic [NUM_STREAMS-1:0] err_ovf;
    logic [NUM_STREAMS-1:0] err_novaddr;

    logic [NUM_STREAMS-1:0] vaddr_we;
    logic [NUM_STREAMS-1:0] size_we;
    logic [NUM_STREAMS-1:0] flush_req;
    logic [NUM_STREAMS-1:0] stat_rd;
    logic [NUM_STREAMS-1:0] full;
    logic [NUM_STREAMS-1:0] deq;
    logic [NUM_STREAMS-1:0] enq;
    logic [NUM_STREAMS-1:0] ovf_ev;
    logic [NUM_STREAMS-1:0] nov_ev;
    logic [DATA_BITS-1:0]   rd_next;

    // Head-of-queue presentation: valid from occupancy, data straight from the read slot.
    always_comb begin
        buf_valid = '0;
        buf_vaddr = '0;
        buf_size  = '0;
        for (int s = 0; s < NUM_STREAMS; s++) begin
            buf_valid[s] = (count[s] != '0);
            buf_vaddr[s*VADDR_BITS +: VADDR_BITS] = mem_vaddr[s][rd_ptr[s]];
            buf_size[s*SIZE_BITS +: SIZE_BITS]    = mem_size[s][rd_ptr[s]];
        end
    end

    // Register decode plus enqueue/dequeue/error qualification per stream.
    always_comb begin
        vaddr_we  = '0;
        size_we   = '0;
        flush_req = '0;
        stat_rd   = '0;
        full      = '0;
        deq       = '0;
        enq       = '0;
        ovf_ev    = '0;
        nov_ev    = '0;
        for (int s = 0; s < NUM_STREAMS; s++) begin
            vaddr_we[s]  = wr_valid && (wr_addr == ADDR_BITS'(4 * s));
            size_we[s]   = wr_valid && (wr_addr == ADDR_BITS'(4 * s + 1));
            flush_req[s] = wr_valid && ((wr_addr == ADDR_BITS'(4 * s + 2)) ||
                                        (wr_addr == FLUSH_ALL_ADDR));
            stat_rd[s]   = rd_valid && (rd_addr == ADDR_BITS'(4 * s + 3));
            full[s]      = (count[s] == CNT_BITS'(DEPTH));
            deq[s]       = buf_valid[s] && buf_ready[s];
            nov_ev[s]    = size_we[s] && !staged[s];
            ovf_ev[s]    = size_we[s] && staged[s] && full[s] && !deq[s];
            enq[s]       = size_we[s] && staged[s] && (!full[s] || deq[s]);
        end
    end

    // Read mux sees pre-write state, so a status read reflects the cycle it was issued in.
    always_comb begin
        rd_next = '0;
        if (rd_addr == ID_ADDR) begin
            rd_next = DATA_BITS'(BLOCK_ID);
        end
        for (int s = 0; s < NUM_STREAMS; s++) begin
            if (rd_addr == ADDR_BITS'(4 * s + 3)) begin
                rd_next = DATA_BITS'({err_novaddr[s], err_ovf[s], count[s]});
            end
        end
    end

    // Descriptor storage; no reset needed since occupancy gates visibility.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_STREAMS; s++) begin
            if (enq[s]) begin
                mem_vaddr[s][wr_ptr[s]] <= staged_vaddr[s];
                mem_size[s][wr_ptr[s]]  <= wr_data[SIZE_BITS-1:0];
            end
        end
    end

    // Queue control: pointers, occupancy, staging and sticky errors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush       <= '0;
            staged      <= '0;
            err_ovf     <= '0;
            err_novaddr <= '0;
            for (int s = 0; s < NUM_STREAMS; s++) begin
                wr_ptr[s]       <= '0;
                rd_ptr[s]       <= '0;
                count[s]        <= '0;
                staged_vaddr[s] <= '0;
            end
        end else begin
            flush <= flush_req;
            for (int s = 0; s < NUM_STREAMS; s++) begin
                err_ovf[s]     <= (err_ovf[s] && !stat_rd[s]) || ovf_ev[s];
                err_novaddr[s] <= (err_novaddr[s] && !stat_rd[s]) || nov_ev[s];
                if (flush_req[s]) begin
                    wr_ptr[s] <= '0;
                    rd_ptr[s] <= '0;
                    count[s]  <= '0;
                    staged[s] <= 1'b0;
                end else begin
                    if (enq[s]) begin
                        wr_ptr[s] <= wr_ptr[s] + 1'b1;
                        staged[s] <= 1'b0;
                    end else if (vaddr_we[s]) begin
                        staged[s]       <= 1'b1;
                        staged_vaddr[s] <= wr_data[VADDR_BITS-1:0];
                    end
                    if (deq[s]) begin
                        rd_ptr[s] <= rd_ptr[s] + 1'b1;
                    end
                    if (enq[s] && !deq[s]) begin
                        count[s] <= count[s] + 1'b1;
                    end else if (!enq[s] && deq[s]) begin
                        count[s] <= count[s] - 1'b1;
                    end
                end
            end
        end
    end

    // Read response is a single-cycle registered strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_resp_valid <= 1'b0;
            rd_data       <= '0;
        end else begin
            rd_resp_valid <= rd_valid;
            rd_data       <= rd_valid ? rd_next : '0;
        end
    end
endmodule

// File: tb/tb_mem_config_queue.sv
// Scoreboard bench for mem_config_queue: descriptors are pushed on SIZE
// writes and popped when the stream's head is handshaken out.
module tb_mem_config_queue;
    localparam int NS = 4;
    localparam int DEPTH = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wr_valid = 1'b0;
    logic [7:0]      wr_addr = '0;
    logic [63:0]     wr_data = '0;
    logic            rd_valid = 1'b0;
    logic [7:0]      rd_addr = '0;
    logic            rd_resp_valid;
    logic [63:0]     rd_data;
    logic [NS-1:0]   buf_valid;
    logic [NS-1:0]   buf_ready = '0;
    logic [NS*64-1:0] buf_vaddr;
    logic [NS*32-1:0] buf_size;
    logic [NS-1:0]   flush;

    int vectors = 0;
    int miscompares = 0;
    logic [95:0] sb [NS][$];

    mem_config_queue dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_addr(rd_addr),
        .rd_resp_valid(rd_resp_valid), .rd_data(rd_data),
        .buf_valid(buf_valid), .buf_ready(buf_ready),
        .buf_vaddr(buf_vaddr), .buf_size(buf_size), .flush(flush)
    );

    always #5 clk = ~clk;

    function automatic logic [95:0] head(input int s);
        return {buf_vaddr[s*64 +: 64], buf_size[s*32 +: 32]};
    endfunction

    task automatic cfg_wr(input logic [7:0] a, input logic [63:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic cfg_rd(input logic [7:0] a, output logic [63:0] d, output logic v);
        rd_valid = 1'b1; rd_addr = a;
        @(posedge clk); #1;
        rd_valid = 1'b0;
        d = rd_data; v = rd_resp_valid;
    endtask

    task automatic put_desc(input int s, input logic [63:0] va, input logic [31:0] sz,
                            input bit keep);
        cfg_wr(8'(4 * s), va);
        cfg_wr(8'(4 * s + 1), {32'h0, sz});
        if (keep) sb[s].push_back({va, sz});
    endtask

    task automatic test_reset;
        logic [63:0] d; logic v;
        vectors++;
        if (buf_valid !== '0) begin miscompares++; $display("FAIL reset_valid got %h want 0", buf_valid); end
        vectors++;
        if (flush !== '0) begin miscompares++; $display("FAIL reset_flush got %h want 0", flush); end
        vectors++;
        if (rd_resp_valid !== 1'b0 || rd_data !== '0) begin
            miscompares++; $display("FAIL reset_rd got %b/%h want 0/0", rd_resp_valid, rd_data);
        end
        cfg_rd(8'd3, d, v);
        vectors++;
        if (v !== 1'b1 || d !== 64'h0) begin
            miscompares++; $display("FAIL reset_status got %b/%h want 1/0", v, d);
        end
    endtask

    task automatic test_basic;
        logic [63:0] d; logic v; logic [95:0] e;
        put_desc(1, 64'h1000, 32'h200, 1'b1);
        vectors++;
        if (buf_valid !== 4'b0010) begin miscompares++; $display("FAIL basic_valid got %b want 0010", buf_valid); end
        buf_ready[1] = 1'b1;
        e = sb[1].pop_front();
        vectors++;
        if (head(1) !== e) begin miscompares++; $display("FAIL basic_head got %h want %h", head(1), e); end
        @(posedge clk); #1;
        buf_ready[1] = 1'b0;
        vectors++;
        if (buf_valid[1] !== 1'b0) begin miscompares++; $display("FAIL basic_drop got %b want 0", buf_valid[1]); end
        cfg_rd(8'd7, d, v);
        vectors++;
        if (v !== 1'b1 || d !== 64'h0) begin miscompares++; $display("FAIL basic_status got %b/%h want 1/0", v, d); end
    endtask

    task automatic test_overflow;
        logic [63:0] d; logic v; logic [95:0] e;
        for (int k = 0; k <= DEPTH; k++)
            put_desc(0, 64'h1_0000 + 64'(k) * 64'h100, 32'(k + 1), k < DEPTH);
        cfg_rd(8'd3, d, v);
        vectors++;
        if (d !== 64'hC0) begin miscompares++; $display("FAIL ovf_status got %h want c0", d); end
        cfg_rd(8'd3, d, v);
        vectors++;
        if (d !== 64'h40) begin miscompares++; $display("FAIL ovf_clear got %h want 40", d); end
        buf_ready[0] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            e = sb[0].pop_front();
            vectors++;
            if (buf_valid[0] !== 1'b1 || head(0) !== e) begin
                miscompares++; $display("FAIL ovf_drain%0d got %b/%h want 1/%h", i, buf_valid[0], head(0), e);
            end
            @(posedge clk); #1;
        end
        buf_ready[0] = 1'b0;
        vectors++;
        if (buf_valid[0] !== 1'b0) begin miscompares++; $display("FAIL ovf_empty got %b want 0", buf_valid[0]); end
    endtask

    task automatic test_novaddr;
        logic [63:0] d; logic v; logic [95:0] e;
        cfg_wr(8'd9, 64'h40);
        vectors++;
        if (buf_valid[2] !== 1'b0) begin miscompares++; $display("FAIL nov_valid got %b want 0", buf_valid[2]); end
        cfg_rd(8'd11, d, v);
        vectors++;
        if (d !== 64'h100) begin miscompares++; $display("FAIL nov_status got %h want 100", d); end
        put_desc(2, 64'h8000, 32'h40, 1'b1);
        buf_ready[2] = 1'b1;
        e = sb[2].pop_front();
        vectors++;
        if (buf_valid[2] !== 1'b1 || head(2) !== e) begin
            miscompares++; $display("FAIL nov_desc got %b/%h want 1/%h", buf_valid[2], head(2), e);
        end
        @(posedge clk); #1;
        buf_ready[2] = 1'b0;
        cfg_rd(8'd11, d, v);
        vectors++;
        if (d !== 64'h0) begin miscompares++; $display("FAIL nov_after got %h want 0", d); end
    endtask

    task automatic test_flush;
        logic [63:0] d; logic v;
        put_desc(1, 64'hAA00, 32'h11, 1'b1);
        for (int k = 0; k < 3; k++) put_desc(3, 64'hB000 + 64'(k), 32'(k), 1'b1);
        cfg_rd(8'd15, d, v);
        vectors++;
        if (d !== 64'h3) begin miscompares++; $display("FAIL fl_pre got %h want 3", d); end
        buf_ready[3] = 1'b1;
        cfg_wr(8'd14, 64'hDEAD);
        buf_ready[3] = 1'b0;
        sb[3].delete();
        vectors++;
        if (flush !== 4'b1000) begin miscompares++; $display("FAIL fl_pulse got %b want 1000", flush); end
        vectors++;
        if (buf_valid !== 4'b0010) begin miscompares++; $display("FAIL fl_valid got %b want 0010", buf_valid); end
        vectors++;
        if (head(1) !== sb[1][0]) begin miscompares++; $display("FAIL fl_other got %h want %h", head(1), sb[1][0]); end
        cfg_rd(8'd15, d, v);
        vectors++;
        if (flush !== 4'b0000 || d !== 64'h0) begin
            miscompares++; $display("FAIL fl_after got %b/%h want 0000/0", flush, d);
        end
        put_desc(0, 64'h1, 32'h1, 1'b0);
        cfg_wr(8'd16, 64'h0);
        for (int s = 0; s < NS; s++) sb[s].delete();
        vectors++;
        if (flush !== 4'b1111 || buf_valid !== 4'b0000) begin
            miscompares++; $display("FAIL fl_all got %b/%b want 1111/0000", flush, buf_valid);
        end
        @(posedge clk); #1;
        vectors++;
        if (flush !== 4'b0000) begin miscompares++; $display("FAIL fl_all_end got %b want 0000", flush); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] d; logic v; logic [95:0] e; logic [63:0] va;
        for (int k = 0; k < DEPTH; k++)
            put_desc(0, 64'h2_0000 + 64'(k), 32'(100 + k), 1'b1);
        buf_ready[0] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            va = 64'h3_0000 + 64'(k);
            for (int ph = 0; ph < 2; ph++) begin
                wr_valid = 1'b1;
                wr_addr = 8'(ph);
                wr_data = (ph == 0) ? va : 64'(500 + k);
                e = sb[0].pop_front();
                vectors++;
                if (buf_valid[0] !== 1'b1 || head(0) !== e) begin
                    miscompares++; $display("FAIL b2b_%0d_%0d got %b/%h want 1/%h", k, ph, buf_valid[0], head(0), e);
                end
                if (ph == 1) sb[0].push_back({va, 32'(500 + k)});
                @(posedge clk); #1;
            end
            wr_valid = 1'b0;
        end
        for (int i = 0; i < DEPTH && sb[0].size() != 0; i++) begin
            e = sb[0].pop_front();
            vectors++;
            if (buf_valid[0] !== 1'b1 || head(0) !== e) begin
                miscompares++; $display("FAIL b2b_drain%0d got %b/%h want 1/%h", i, buf_valid[0], head(0), e);
            end
            @(posedge clk); #1;
        end
        buf_ready[0] = 1'b0;
        cfg_rd(8'd3, d, v);
        vectors++;
        if (d !== 64'h0 || buf_valid[0] !== 1'b0) begin
            miscompares++; $display("FAIL b2b_status got %h/%b want 0/0", d, buf_valid[0]);
        end
    endtask

    task automatic test_id_unmapped;
        logic [63:0] d; logic v;
        cfg_rd(8'd17, d, v);
        vectors++;
        if (v !== 1'b1 || d !== 64'h3) begin miscompares++; $display("FAIL id got %b/%h want 1/3", v, d); end
        @(posedge clk); #1;
        vectors++;
        if (rd_resp_valid !== 1'b0) begin miscompares++; $display("FAIL id_strobe got %b want 0", rd_resp_valid); end
        cfg_rd(8'd20, d, v);
        vectors++;
        if (v !== 1'b1 || d !== 64'h0) begin miscompares++; $display("FAIL unmapped got %b/%h want 1/0", v, d); end
        cfg_rd(8'd0, d, v);
        vectors++;
        if (d !== 64'h0) begin miscompares++; $display("FAIL wo_read got %h want 0", d); end
    endtask

    task automatic test_async_reset;
        logic [63:0] d; logic v;
        put_desc(0, 64'h77, 32'h7, 1'b0);
        put_desc(2, 64'h99, 32'h9, 1'b0);
        vectors++;
        if (buf_valid !== 4'b0101) begin miscompares++; $display("FAIL ar_pre got %b want 0101", buf_valid); end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (buf_valid !== 4'b0000 || flush !== 4'b0000) begin
            miscompares++; $display("FAIL ar_now got %b/%b want 0000/0000", buf_valid, flush);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        cfg_rd(8'd3, d, v);
        vectors++;
        if (d !== 64'h0 || flush !== 4'b0000) begin
            miscompares++; $display("FAIL ar_status got %h/%b want 0/0000", d, flush);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_novaddr();
        test_flush();
        test_back_to_back();
        test_id_unmapped();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
